// File: rtl/power_07bc_dec.sv
// Receive-side decoder for the power_07bc lane-masked encoding.
// Decoded beats are queued in a 2-entry FIFO; saturating beat/flip statistics are kept.
module power_07bc_dec #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned FW    = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_y,
  input  logic [W-1:0]     in_k1,
  input  logic [W-1:0]     in_k3,
  input  logic [W-1:0]     in_k4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_d,
  output logic [FW-1:0]    out_flips,
  input  logic             clr,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] flip_cnt
);

  logic [W-1:0]  mask_c;
  logic [W-1:0]  dec_c;
  logic [FW-1:0] flips_c;

  logic [W-1:0]  mem_d [2];
  logic [FW-1:0] mem_f [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  logic          push_c;
  logic          pop_c;
  logic [CNT_W:0] flip_sum_c;

  // Lane mask, decoded data and popcount of inverted lanes
  always_comb begin
    mask_c  = in_k4 & ~in_k1 & ~in_k3;
    dec_c   = in_y ^ mask_c;
    flips_c = '0;
    for (int i = 0; i < W; i++) begin
      flips_c = flips_c + FW'(mask_c[i]);
    end
  end

  assign in_ready   = (count != 2'd2);
  assign out_valid  = (count != 2'd0);
  assign out_d      = out_valid ? mem_d[rd_ptr] : '0;
  assign out_flips  = out_valid ? mem_f[rd_ptr] : '0;
  assign push_c     = in_valid & in_ready;
  assign pop_c      = out_valid & out_ready;
  assign flip_sum_c = {1'b0, flip_cnt} + (CNT_W + 1)'(flips_c);

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_d[0] <= '0;
      mem_d[1] <= '0;
      mem_f[0] <= '0;
      mem_f[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push_c) begin
        mem_d[wr_ptr] <= dec_c;
        mem_f[wr_ptr] <= flips_c;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_c) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating statistics; clear wins over a same-cycle transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      flip_cnt <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
      flip_cnt <= '0;
    end else if (push_c) begin
      if (beat_cnt != {CNT_W{1'b1}}) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      flip_cnt <= flip_sum_c[CNT_W] ? {CNT_W{1'b1}} : flip_sum_c[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_power_07bc_dec.sv
// Self-checking bench for power_07bc_dec (W=8, CNT_W=4) with a scoreboard of decoded beats.
module tb_power_07bc_dec;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned FW    = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [FW-1:0] f;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_y;
  logic [W-1:0]     in_k1;
  logic [W-1:0]     in_k3;
  logic [W-1:0]     in_k4;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_d;
  logic [FW-1:0]    out_flips;
  logic             clr;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] flip_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] mon_m;

  power_07bc_dec #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_k1(in_k1), .in_k3(in_k3), .in_k4(in_k4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_flips(out_flips),
    .clr(clr), .beat_cnt(beat_cnt), .flip_cnt(flip_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: handshakes sampled mid-cycle, they complete at the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_out: got d=%h flips=%0d, expected no output", out_d, out_flips);
        end else begin
          mon_e = sb.pop_front();
          if (out_d !== mon_e.d || out_flips !== mon_e.f) begin
            errors++;
            $display("FAIL sb_out: got d=%h flips=%0d, expected d=%h flips=%0d",
                     out_d, out_flips, mon_e.d, mon_e.f);
          end
        end
      end
      if (in_valid && in_ready) begin
        mon_m = in_k4 & ~in_k1 & ~in_k3;
        sb.push_back({in_y ^ mon_m, FW'($countones(mon_m))});
      end
    end
  end

  task automatic wait_accept(input string name);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: in_ready stayed low, expected acceptance", name);
    end
  endtask

  task automatic drive(input logic [W-1:0] y, k1, k3, k4, input string name);
    in_y = y; in_k1 = k1; in_k3 = k3; in_k4 = k4;
    in_valid = 1;
    wait_accept(name);
  endtask

  task automatic drain(input string name);
    bit done = 0;
    out_ready = 1;
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid) done = 1;
    end
    out_ready = 0;
    checks++;
    if (!done || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: out_valid=%b sb_left=%0d, expected 0 and 0", name, out_valid, sb.size());
    end
  endtask

  task automatic do_clr();
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
  endtask

  task automatic check8(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_y = 8'hFF; in_k1 = 0; in_k3 = 0; in_k4 = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check8("reset_in_ready", W'(in_ready), 8'h01);
    check8("reset_out_valid", W'(out_valid), 8'h00);
    check8("reset_out_d", out_d, 8'h00);
    check8("reset_beat_cnt", W'(beat_cnt), 8'h00);
    check8("reset_flip_cnt", W'(flip_cnt), 8'h00);
    in_valid = 0;
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    drive(8'h3C, 8'h00, 8'h00, 8'h00, "reset_first");
    check8("reset_first_latency", W'(out_valid), 8'h01);
    check8("reset_first_d", out_d, 8'h3C);
    drain("reset_first");
  endtask

  task automatic test_full_mask();
    do_clr();
    drive(8'hA5, 8'h00, 8'h00, 8'hFF, "full");
    check8("full_out_d", out_d, 8'h5A);
    check8("full_out_flips", W'(out_flips), 8'd8);
    check8("full_beat_cnt", W'(beat_cnt), 8'd1);
    check8("full_flip_cnt", W'(flip_cnt), 8'd8);
    drain("full");
  endtask

  task automatic test_partial_mask();
    drive(8'hA5, 8'h0F, 8'h30, 8'hFF, "partial");
    check8("partial_out_d", out_d, 8'h65);
    check8("partial_out_flips", W'(out_flips), 8'd2);
    drain("partial");
    drive(8'hA5, 8'h0F, 8'h30, 8'h00, "nomask");
    check8("nomask_out_d", out_d, 8'hA5);
    check8("nomask_out_flips", W'(out_flips), 8'd0);
    drain("nomask");
  endtask

  task automatic test_backpressure();
    do_clr();
    out_ready = 0;
    drive(8'h11, 8'h00, 8'h00, 8'h00, "bp_11");
    drive(8'h22, 8'h00, 8'h00, 8'h00, "bp_22");
    in_y = 8'h33; in_k1 = 0; in_k3 = 0; in_k4 = 0;
    in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    check8("bp_in_ready_low", W'(in_ready), 8'h00);
    check8("bp_beat_cnt", W'(beat_cnt), 8'd2);
    check8("bp_head_stable", out_d, 8'h11);
    out_ready = 1;
    wait_accept("bp_33");
    drain("bp");
    check8("bp_beat_cnt_final", W'(beat_cnt), 8'd3);
  endtask

  task automatic test_simultaneous();
    do_clr();
    out_ready = 0;
    drive(8'h44, 8'h00, 8'h00, 8'h00, "sim_44");
    out_ready = 1;
    drive(8'h55, 8'h00, 8'h00, 8'h00, "sim_55");
    out_ready = 0;
    check8("sim_out_valid", W'(out_valid), 8'h01);
    check8("sim_new_head", out_d, 8'h55);
    check8("sim_count_one", W'(in_ready), 8'h01);
    clr = 1;
    drive(8'h0F, 8'h00, 8'h00, 8'hFF, "sim_clr");
    clr = 0;
    check8("clr_beat_cnt", W'(beat_cnt), 8'd0);
    check8("clr_flip_cnt", W'(flip_cnt), 8'd0);
    drain("sim");
  endtask

  task automatic test_back_to_back();
    int start;
    do_clr();
    out_ready = 1;
    start = cyc;
    for (int i = 0; i < 20; i++) begin
      drive(W'($urandom), 8'h00, 8'h00, 8'hFF, "b2b");
    end
    check8("b2b_cycles", W'(cyc - start), 8'd20);
    check8("sat_beat_cnt", W'(beat_cnt), 8'd15);
    check8("sat_flip_cnt", W'(flip_cnt), 8'd15);
    drain("b2b");
  endtask

  task automatic test_reset_midstream();
    out_ready = 0;
    drive(8'h77, 8'h00, 8'h00, 8'h00, "mid_a");
    drive(8'h88, 8'h00, 8'h00, 8'h00, "mid_b");
    check8("mid_full", W'(in_ready), 8'h00);
    #2 rst_n = 0;
    #1;
    check8("mid_out_valid_async", W'(out_valid), 8'h00);
    check8("mid_out_d_async", out_d, 8'h00);
    check8("mid_beat_cnt_async", W'(beat_cnt), 8'd0);
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    out_ready = 1;
    @(posedge clk);
    #1;
    check8("mid_lost_out_valid", W'(out_valid), 8'h00);
    check8("mid_sb_empty", W'(sb.size()), 8'd0);
    out_ready = 0;
  endtask

  initial begin
    clk = 0; rst_n = 0; in_valid = 0; out_ready = 0; clr = 0;
    in_y = 0; in_k1 = 0; in_k3 = 0; in_k4 = 0;
    test_reset();
    test_full_mask();
    test_partial_mask();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
